alex_filter_sequencer: RTL and testbench

//  Parametrised Alex filter-bank selector: maps tuned frequency to one of NUM_FILT filters

---
 rtl/alex_pkg.sv | 10 +
 rtl/alex_filter_sequencer_if.sv | 28 ++
 rtl/alex_band_compare.sv | 64 ++++++
 rtl/alex_filter_sequencer.sv | 83 ++++++++
 tb/tb_alex_filter_sequencer.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/alex_pkg.sv
// alex_pkg: state encoding, counter width and reset threshold table for the Alex filter sequencer
package alex_pkg;
  typedef enum logic [1:0] {IDLE, BREAK, SETTLE} state_t;
  localparam int CNT_W = 16;
  localparam logic [31:0] THR_DEF [5] = '{32'd1_500_000, 32'd6_500_000, 32'd9_500_000, 32'd13_000_000, 32'd20_000_000};
  // Banks wider than six filters get open-ended upper edges until software programs them
  function automatic logic [31:0] thr_default(input int k);
    return k < 5 ? THR_DEF[k] : 32'hFFFF_FFFF;
  endfunction
endpackage

// File: rtl/alex_filter_sequencer_if.sv
// alex_filter_sequencer_if: control/status bundle between C&C registers and the filter sequencer
//   master drives frequency/freq_valid and the threshold write port; slave drives filt_sel/band_idx/busy/done.
//   ALEX_MANUAL_OVERRIDE_EN adds manual_en/manual_idx.
interface alex_filter_sequencer_if #(parameter int NUM_FILT = 6, FREQ_W = 32);
  logic [FREQ_W-1:0] frequency, thr_data;
  logic freq_valid, thr_wr, busy, done;
  logic [$clog2(NUM_FILT-1)-1:0] thr_addr;
  logic [NUM_FILT-1:0] filt_sel;
  logic [$clog2(NUM_FILT)-1:0] band_idx;
`ifdef ALEX_MANUAL_OVERRIDE_EN
  logic manual_en;
  logic [$clog2(NUM_FILT)-1:0] manual_idx;
`endif
  modport master (
    output frequency, freq_valid, thr_wr, thr_addr, thr_data,
`ifdef ALEX_MANUAL_OVERRIDE_EN
    manual_en, manual_idx,
`endif
    input filt_sel, band_idx, busy, done
  );
  modport slave (
    input frequency, freq_valid, thr_wr, thr_addr, thr_data,
`ifdef ALEX_MANUAL_OVERRIDE_EN
    manual_en, manual_idx,
`endif
    output filt_sel, band_idx, busy, done
  );
endinterface

// File: rtl/alex_band_compare.sv
// alex_band_compare: programmable threshold table and hysteresis comparator
//   clock, reset_n            clock / synchronous active-low reset (table back to defaults)
//   thr_wr/thr_addr/thr_data  table write; addresses >= NUM_FILT-1 ignored
//   freq, cur, eval           frequency under test, committed band, evaluate strobe
//   target, change            registered result; change pulses one cycle after eval when a move is due
//   ALEX_MANUAL_OVERRIDE_EN   adds manual_en/manual_idx, which bypass thresholds and hysteresis
module alex_band_compare
  import alex_pkg::*;
#(
  parameter int NUM_FILT = 6,
  parameter int FREQ_W = 32,
  parameter int HYST_HZ = 50000,
  localparam int IW = $clog2(NUM_FILT),
  localparam int AW = $clog2(NUM_FILT - 1)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              thr_wr,
  input  logic [AW-1:0]     thr_addr,
  input  logic [FREQ_W-1:0] thr_data,
  input  logic [FREQ_W-1:0] freq,
  input  logic [IW-1:0]     cur,
  input  logic              eval,
`ifdef ALEX_MANUAL_OVERRIDE_EN
  input  logic              manual_en,
  input  logic [IW-1:0]     manual_idx,
`endif
  output logic [IW-1:0]     target,
  output logic              change
);
  logic [FREQ_W-1:0] thr [NUM_FILT-1];
  logic [FREQ_W-1:0] e_lo, e_hi, lo, hi;
  logic [FREQ_W:0] lo_x, hi_x;
  logic [IW-1:0] raw, tgt;
  logic go;
  always_comb begin
    // Walk high to low so the lowest matching edge wins, even for non-monotonic tables
    raw = IW'(NUM_FILT - 1);
    for (int k = NUM_FILT - 2; k >= 0; k--) raw = freq < thr[k] ? IW'(k) : raw;
    e_lo = |cur ? thr[cur - 1'b1] : '0;
    e_hi = cur < IW'(NUM_FILT - 1) ? thr[cur] : '1;
    // One extra bit exposes borrow/carry so the edges clamp instead of wrapping
    lo_x = {1'b0, e_lo} - (FREQ_W + 1)'(HYST_HZ);
    hi_x = {1'b0, e_hi} + (FREQ_W + 1)'(HYST_HZ);
    lo = lo_x[FREQ_W] ? '0 : lo_x[FREQ_W-1:0];
    hi = hi_x[FREQ_W] ? '1 : hi_x[FREQ_W-1:0];
    go = (|cur && freq < lo) || (cur < IW'(NUM_FILT - 1) && freq >= hi);
    tgt = raw;
`ifdef ALEX_MANUAL_OVERRIDE_EN
    tgt = manual_en ? (manual_idx > IW'(NUM_FILT - 1) ? IW'(NUM_FILT - 1) : manual_idx) : raw;
    go = go || manual_en;
`endif
  end
  always_ff @(posedge clock)
    if (!reset_n) begin
      for (int k = 0; k < NUM_FILT - 1; k++) thr[k] <= FREQ_W'(thr_default(k));
      target <= '0;
      change <= 1'b0;
    end else begin
      if (thr_wr && thr_addr < AW'(NUM_FILT - 1)) thr[thr_addr] <= thr_data;
      target <= eval ? tgt : target;
      change <= eval && go && tgt != cur;
    end
endmodule

// File: rtl/alex_filter_sequencer.sv
// alex_filter_sequencer: Alex filter-bank selector with break-before-make relay sequencing
//   clock, reset_n  clock / synchronous active-low reset (aborts any sequence, bypass selected)
//   bus (slave)     frequency/freq_valid, threshold write port, filt_sel/band_idx/busy/done
//   ALEX_MANUAL_OVERRIDE_EN  adds manual_en/manual_idx band forcing on the bus
//   BREAK_CYC/SETTLE_CYC must fit the CNT_W-bit counter
module alex_filter_sequencer
  import alex_pkg::*;
#(
  parameter int NUM_FILT = 6,
  parameter int FREQ_W = 32,
  parameter int HYST_HZ = 50000,
  parameter int BREAK_CYC = 480,
  parameter int SETTLE_CYC = 4800
) (
  input logic clock,
  input logic reset_n,
  alex_filter_sequencer_if.slave bus
);
  localparam int IW = $clog2(NUM_FILT);
  state_t st, nxt;
  logic [CNT_W-1:0] cnt;
  logic [FREQ_W-1:0] pend;
  logic [IW-1:0] tgt;
  logic chg, eval_req, eval, man_evt;
`ifdef ALEX_MANUAL_OVERRIDE_EN
  logic man_en_q;
  logic [IW-1:0] man_idx_q;
  assign man_evt = {bus.manual_en, bus.manual_idx} != {man_en_q, man_idx_q};
`else
  assign man_evt = 1'b0;
`endif
  // Requests wait while busy; also hold off while a change result is about to be acted on
  assign eval = eval_req && st == IDLE && !chg;
  alex_band_compare #(.NUM_FILT(NUM_FILT), .FREQ_W(FREQ_W), .HYST_HZ(HYST_HZ)) cmp (
    .clock,
    .reset_n,
    .thr_wr(bus.thr_wr),
    .thr_addr(bus.thr_addr),
    .thr_data(bus.thr_data),
    .freq(pend),
    .cur(bus.band_idx),
    .eval,
`ifdef ALEX_MANUAL_OVERRIDE_EN
    .manual_en(bus.manual_en),
    .manual_idx(bus.manual_idx),
`endif
    .target(tgt),
    .change(chg)
  );
  always_comb begin
    nxt = st;
    if (st == IDLE && chg) nxt = BREAK_CYC > 0 ? BREAK : SETTLE;
    else if (st == BREAK && cnt == '0) nxt = SETTLE;
    else if (st == SETTLE && cnt == '0) nxt = IDLE;
  end
  always_ff @(posedge clock)
    if (!reset_n) begin
      st <= IDLE;
      cnt <= '0;
      pend <= '0;
      eval_req <= 1'b0;
      bus.band_idx <= '0;
      bus.done <= 1'b0;
`ifdef ALEX_MANUAL_OVERRIDE_EN
      man_en_q <= 1'b0;
      man_idx_q <= '0;
`endif
    end else begin
      st <= nxt;
      cnt <= nxt == st ? cnt - CNT_W'(cnt != '0) :
             nxt == BREAK ? CNT_W'(BREAK_CYC - 1) : CNT_W'(SETTLE_CYC > 0 ? SETTLE_CYC - 1 : 0);
      pend <= bus.freq_valid ? bus.frequency : pend;
      eval_req <= bus.freq_valid || man_evt || (eval_req && !eval);
      bus.band_idx <= nxt == SETTLE && st != SETTLE ? tgt : bus.band_idx;
      bus.done <= st == SETTLE && nxt == IDLE;
`ifdef ALEX_MANUAL_OVERRIDE_EN
      man_en_q <= bus.manual_en;
      man_idx_q <= bus.manual_idx;
`endif
    end
  assign bus.busy = st != IDLE;
  assign bus.filt_sel = st == BREAK ? '0 : NUM_FILT'(1) << bus.band_idx;
endmodule

// File: tb/tb_alex_filter_sequencer.sv
// tb_alex_filter_sequencer: directed stimulus with a done-driven scoreboard for alex_filter_sequencer
module tb_alex_filter_sequencer;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;
  alex_filter_sequencer_if #(.NUM_FILT(6), .FREQ_W(32)) bus ();
  alex_filter_sequencer #(
    .NUM_FILT(6), .FREQ_W(32), .HYST_HZ(50000), .BREAK_CYC(2), .SETTLE_CYC(8)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(bus)
  );
  typedef struct {int band; int filt; int blen; int brk;} exp_t;
  exp_t q[$];
  int checks = 0;
  int fails = 0;
  int blen = 0;
  int brk = 0;
  task automatic chk(input string n, input longint a, input longint e);
    checks++;
    if (a != e) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic wait_n(input int n);
    repeat (n) step();
  endtask
  task automatic push(input int band, input int filt);
    q.push_back('{band, filt, 10, 2});
  endtask
  task automatic send(input logic [31:0] f);
    bus.frequency = f;
    bus.freq_valid = 1'b1;
    step();
    bus.freq_valid = 1'b0;
  endtask
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus.thr_wr = 1'b1;
    bus.thr_addr = a;
    bus.thr_data = d;
    step();
    bus.thr_wr = 1'b0;
  endtask
  always @(negedge clock) begin : mon
    exp_t e;
    if (!reset_n) begin
      blen = 0;
      brk = 0;
    end else begin
      if (bus.busy) begin
        blen++;
        if (bus.filt_sel == '0) brk++;
      end
      if (bus.done) begin
        if (q.size() == 0) chk("unexpected done", 1, 0);
        else begin
          e = q.pop_front();
          chk("done band_idx", bus.band_idx, e.band);
          chk("done filt_sel", bus.filt_sel, e.filt);
          chk("busy length", blen, e.blen);
          chk("break length", brk, e.brk);
        end
        blen = 0;
        brk = 0;
      end
    end
  end
  initial begin
    bus.frequency = '0;
    bus.freq_valid = 1'b0;
    bus.thr_wr = 1'b0;
    bus.thr_addr = '0;
    bus.thr_data = '0;
`ifdef ALEX_MANUAL_OVERRIDE_EN
    bus.manual_en = 1'b0;
    bus.manual_idx = '0;
`endif
    step();
    chk("reset filt_sel", bus.filt_sel, 6'b000001);
    chk("reset band_idx", bus.band_idx, 0);
    chk("reset busy", bus.busy, 0);
    chk("reset done", bus.done, 0);
    reset_n = 1'b1;
    push(2, 6'b000100);
    send(32'd7_000_000);
    chk("busy +0", bus.busy, 0);
    step();
    chk("busy +1", bus.busy, 0);
    step();
    chk("busy +2", bus.busy, 1);
    chk("break filt_sel", bus.filt_sel, 0);
    wait_n(20);
    send(32'd6_480_000);
    wait_n(20);
    chk("hysteresis hold band", bus.band_idx, 2);
    push(1, 6'b000010);
    send(32'd6_440_000);
    wait_n(20);
    wr(3'd0, 32'd2_000_000);
    push(0, 6'b000001);
    send(32'd1_800_000);
    wait_n(20);
    bus.thr_wr = 1'b1;
    bus.thr_addr = 3'd0;
    bus.thr_data = 32'd1_000_000;
    bus.frequency = 32'd1_200_000;
    bus.freq_valid = 1'b1;
    step();
    bus.thr_wr = 1'b0;
    bus.freq_valid = 1'b0;
    push(1, 6'b000010);
    wait_n(20);
    push(5, 6'b100000);
    send(32'd30_000_000);
    wait_n(6);
    push(4, 6'b010000);
    send(32'd14_000_000);
    chk("mid-settle band", bus.band_idx, 5);
    chk("mid-settle busy", bus.busy, 1);
    wait_n(40);
    send(32'd3_000_000);
    wait_n(2);
    chk("pre-reset break", bus.filt_sel, 0);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("abort filt_sel", bus.filt_sel, 6'b000001);
    chk("abort band_idx", bus.band_idx, 0);
    chk("abort busy", bus.busy, 0);
    send(32'd1_200_000);
    wait_n(20);
    chk("default thr band", bus.band_idx, 0);
    push(1, 6'b000010);
    send(32'd1_800_000);
    wait_n(20);
    chk("scoreboard drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
